// File: rtl/bg_pkg.sv
// Shared definitions for the background fetch sequencer.
//   bgno_width()    : slot index width for a given slot count (minimum 1)
//   BGNO_W          : slot index width for the default four-slot build
//   bgmode_e        : background mode, taken from DISPCNT[2:0]
//   mode_slot_mask(): which of slots 0..3 a background mode can use
package bg_pkg;

  localparam int unsigned NUM_BG_DEFAULT = 4;

  function automatic int unsigned bgno_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BGNO_W = bgno_width(NUM_BG_DEFAULT);

  typedef enum logic [2:0] {
    BGMODE_0 = 3'd0,
    BGMODE_1 = 3'd1,
    BGMODE_2 = 3'd2,
    BGMODE_3 = 3'd3,
    BGMODE_4 = 3'd4,
    BGMODE_5 = 3'd5,
    BGMODE_6 = 3'd6,
    BGMODE_7 = 3'd7
  } bgmode_e;

  // Bit i set means slot i may be used in this mode.
  function automatic logic [3:0] mode_slot_mask(input bgmode_e m);
    logic [3:0] mask;
    case (m)
      BGMODE_0:                     mask = 4'b1111;
      BGMODE_1:                     mask = 4'b0111;
      BGMODE_2:                     mask = 4'b1100;
      BGMODE_3, BGMODE_4, BGMODE_5: mask = 4'b0100;
      default:                      mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/bg_tag_pipe.sv
// Fixed-depth delay line for slot tags.
//   clock : rising-edge clock
//   rst   : synchronous active-high clear of every stage (wins over hold)
//   hold  : freezes every stage while high
//   d     : tag entering stage 0
//   q     : tag leaving the last stage, DEPTH advancing cycles after entry
module bg_tag_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift register; all stages advance together or not at all.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (!hold) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/bg_fetch_sequencer.sv
// Background fetch sequencer: walks slot -> column -> scanline -> frame and
// emits a delayed tag for each slot that will actually be fetched.
//   clock, rst          : clock and synchronous active-high reset
//   dispcnt, bg_enable  : mode (dispcnt[2:0]) and per-slot enables, per slot
//   stall               : freezes counters and tag pipeline
//   col, bgno, row      : current column / slot / scanline
//   frame               : frame parity
//   start_row, new_frame: strobes on the last slot of a line / frame
//   hblank, vblank      : current position is outside the visible area
//   bgused              : current slot is enabled for the current mode
//   tag_*, hcount       : current slot delayed by PIPE_DEPTH cycles
module bg_fetch_sequencer
  import bg_pkg::*;
#(
  parameter int unsigned NUM_BG     = 4,
  parameter int unsigned H_TOTAL    = 308,
  parameter int unsigned V_TOTAL    = 228,
  parameter int unsigned H_VISIBLE  = 240,
  parameter int unsigned V_VISIBLE  = 160,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic [15:0]                     dispcnt,
  input  logic [NUM_BG-1:0]               bg_enable,
  input  logic                            stall,
  output logic [8:0]                      col,
  output logic [bgno_width(NUM_BG)-1:0]   bgno,
  output logic [7:0]                      row,
  output logic                            frame,
  output logic                            start_row,
  output logic                            new_frame,
  output logic                            hblank,
  output logic                            vblank,
  output logic                            bgused,
  output logic [8:0]                      tag_col,
  output logic [bgno_width(NUM_BG)-1:0]   tag_bgno,
  output logic                            tag_valid,
  output logic [7:0]                      hcount
);

  localparam int unsigned SLOT_W = bgno_width(NUM_BG);
  localparam int unsigned TAG_W  = 9 + SLOT_W + 1;

  bgmode_e          mode;
  logic [3:0]       mode_mask;
  logic [NUM_BG-1:0] active;
  logic             slot_wrap;
  logic             col_wrap;
  logic             row_wrap;
  logic             unused_dispcnt;
  logic [TAG_W-1:0] tag_d;
  logic [TAG_W-1:0] tag_q;

  assign mode           = bgmode_e'(dispcnt[2:0]);
  assign mode_mask      = mode_slot_mask(mode);
  assign unused_dispcnt = ^dispcnt[15:3];

  // Slots 0..3 obey the mode table; higher slots only need their enable.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_BG; i++) begin
      active[i] = bg_enable[i] & ((i < 4) ? mode_mask[i[1:0]] : 1'b1);
    end
  end

  assign bgused    = active[bgno];
  assign hblank    = col >= 9'(H_VISIBLE);
  assign vblank    = row >= 8'(V_VISIBLE);

  assign slot_wrap = bgno == SLOT_W'(NUM_BG - 1);
  assign col_wrap  = col == 9'(H_TOTAL - 1);
  assign row_wrap  = row == 8'(V_TOTAL - 1);

  // Strobes are suppressed under reset so a reset never leaves a partial pulse.
  assign start_row = slot_wrap & col_wrap & ~stall & ~rst;
  assign new_frame = start_row & row_wrap;

  // Position counters: slot is the fastest digit, then column, then row.
  always_ff @(posedge clock) begin
    if (rst) begin
      bgno  <= '0;
      col   <= '0;
      row   <= '0;
      frame <= 1'b0;
    end else if (!stall) begin
      if (slot_wrap) begin
        bgno <= '0;
        if (col_wrap) begin
          col <= '0;
          if (row_wrap) begin
            row   <= '0;
            frame <= ~frame;
          end else begin
            row <= row + 8'd1;
          end
        end else begin
          col <= col + 9'd1;
        end
      end else begin
        bgno <= bgno + SLOT_W'(1);
      end
    end
  end

  assign tag_d = {col, bgno, bgused & ~hblank & ~vblank};

  bg_tag_pipe #(
    .WIDTH (TAG_W),
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clock (clock),
    .rst   (rst),
    .hold  (stall),
    .d     (tag_d),
    .q     (tag_q)
  );

  assign tag_col   = tag_q[TAG_W-1 -: 9];
  assign tag_bgno  = tag_q[SLOT_W:1];
  assign tag_valid = tag_q[0];
  assign hcount    = tag_col[7:0];

endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// Randomized scoreboard bench for bg_fetch_sequencer on a reduced raster
// (six slots, three-deep tag pipe) so several full frames fit in the run.
module tb_bg_fetch_sequencer;

  localparam int NB = 6;
  localparam int HT = 20;
  localparam int VT = 8;
  localparam int HV = 15;
  localparam int VV = 6;
  localparam int PD = 3;
  localparam int BW = 3;
  localparam int FRAME_SLOTS = NB * HT * VT;
  localparam int NCYC = 6000;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [15:0]   dispcnt = 16'h0000;
  logic [NB-1:0] bg_enable = '1;

  logic [8:0]    col;
  logic [BW-1:0] bgno;
  logic [7:0]    row;
  logic          frame, start_row, new_frame, hblank, vblank, bgused;
  logic [8:0]    tag_col;
  logic [BW-1:0] tag_bgno;
  logic          tag_valid;
  logic [7:0]    hcount;

  bg_fetch_sequencer #(
    .NUM_BG(NB), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_VISIBLE(HV), .V_VISIBLE(VV), .PIPE_DEPTH(PD)
  ) dut (
    .clock(clock), .rst(rst), .dispcnt(dispcnt), .bg_enable(bg_enable),
    .stall(stall), .col(col), .bgno(bgno), .row(row), .frame(frame),
    .start_row(start_row), .new_frame(new_frame), .hblank(hblank),
    .vblank(vblank), .bgused(bgused), .tag_col(tag_col), .tag_bgno(tag_bgno),
    .tag_valid(tag_valid), .hcount(hcount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0]    col;
    logic [BW-1:0] bgno;
    logic [7:0]    row;
    logic          frame;
    logic          start_row;
    logic          new_frame;
    logic          hblank;
    logic          vblank;
    logic          bgused;
    logic [8:0]    tag_col;
    logic [BW-1:0] tag_bgno;
    logic          tag_valid;
    logic [7:0]    hcount;
  } obs_t;

  typedef struct packed {
    logic [8:0]    col;
    logic [BW-1:0] bgno;
    logic          valid;
  } tag_t;

  obs_t exp_q[$];
  tag_t hist[$];
  int   pos = 0;
  bit   mframe = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   drv_done = 1'b0;

  // Which slots a mode can fetch from, written as plain set membership.
  function automatic bit slot_allowed(input int mode, input int slot);
    if (slot >= 4) return 1'b1;
    case (mode)
      0:       return slot inside {0, 1, 2, 3};
      1:       return slot inside {0, 1, 2};
      2:       return slot inside {2, 3};
      3, 4, 5: return slot == 2;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for the current cycle, then advance the reference model.
  task automatic model_step(input bit r, input bit s, input logic [15:0] dc,
                            input logic [NB-1:0] en);
    obs_t e;
    int   b, c, rw;
    tag_t t;
    b  = pos % NB;
    c  = (pos / NB) % HT;
    rw = pos / (NB * HT);
    e.col       = 9'(c);
    e.bgno      = BW'(b);
    e.row       = 8'(rw);
    e.frame     = mframe;
    e.hblank    = c >= HV;
    e.vblank    = rw >= VV;
    e.bgused    = slot_allowed(int'(dc[2:0]), b) && en[b];
    e.start_row = !r && !s && b == NB - 1 && c == HT - 1;
    e.new_frame = e.start_row && rw == VT - 1;
    if (hist.size() >= PD) t = hist[PD-1];
    else                   t = '0;
    e.tag_col   = t.col;
    e.tag_bgno  = t.bgno;
    e.tag_valid = t.valid;
    e.hcount    = t.col[7:0];
    exp_q.push_back(e);
    if (r) begin
      pos    = 0;
      mframe = 1'b0;
      hist.delete();
    end else if (!s) begin
      hist.push_front('{col: 9'(c), bgno: BW'(b),
                        valid: e.bgused && !e.hblank && !e.vblank});
      if (hist.size() > PD) void'(hist.pop_back());
      pos = pos + 1;
      if (pos == FRAME_SLOTS) begin
        pos    = 0;
        mframe = ~mframe;
      end
    end
  endtask

  // Driver: new inputs each falling edge, expected result queued at once.
  initial begin
    int stall_left = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        rst = 1'b1;
      end else if (cyc < 2 * FRAME_SLOTS) begin
        // Two clean frames first, with occasional short stalls.
        rst = 1'b0;
        if (stall_left > 0) stall_left--;
        else if ($urandom_range(0, 15) == 0) stall_left = $urandom_range(1, 10);
        stall = stall_left > 0;
      end else begin
        rst = $urandom_range(0, 399) == 0;
        if (rst) stall = $urandom_range(0, 1) == 1;
        else     stall = $urandom_range(0, 5) == 0;
      end
      if ($urandom_range(0, 11) == 0) dispcnt = 16'($urandom);
      if ($urandom_range(0, 11) == 0) bg_enable = NB'($urandom);
      model_step(rst, stall, dispcnt, bg_enable);
    end
    drv_done = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: every cycle the DUT presents a full set of outputs; compare it.
  always @(negedge clock) begin
    obs_t a, e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{col, bgno, row, frame, start_row, new_frame, hblank, vblank,
            bgused, tag_col, tag_bgno, tag_valid, hcount};
      tests++;
      if (a !== e) begin
        fails++;
        if (fails <= 20)
          $display("FAIL outputs @%0t: got col=%0d bgno=%0d row=%0d fr=%0b sr=%0b nf=%0b hb=%0b vb=%0b used=%0b tcol=%0d tbg=%0d tv=%0b hc=%0d | want col=%0d bgno=%0d row=%0d fr=%0b sr=%0b nf=%0b hb=%0b vb=%0b used=%0b tcol=%0d tbg=%0d tv=%0b hc=%0d",
                   $time, a.col, a.bgno, a.row, a.frame, a.start_row, a.new_frame,
                   a.hblank, a.vblank, a.bgused, a.tag_col, a.tag_bgno, a.tag_valid,
                   a.hcount, e.col, e.bgno, e.row, e.frame, e.start_row, e.new_frame,
                   e.hblank, e.vblank, e.bgused, e.tag_col, e.tag_bgno, e.tag_valid,
                   e.hcount);
      end
    end
  end

endmodule

// File: doc/bg_fetch_sequencer.md
BG_FETCH_SEQUENCER -- requirements
Module: bg_fetch_sequencer

Interface
REQ-001 Parameter NUM_BG, default 4, number of time-multiplexed background slots per pixel column (legal 1..8).
REQ-002 Parameter H_TOTAL, default 308, columns per scanline including hblank.
REQ-003 Parameter V_TOTAL, default 228, scanlines per frame including vblank.
REQ-004 Parameter H_VISIBLE, default 240, visible columns; V_VISIBLE, default 160, visible rows.
REQ-005 Parameter PIPE_DEPTH, default 2, tag pipeline stages (legal 1..4).
REQ-006 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-007 Port clock, input, 1, system clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port dispcnt, input, 16, DISPCNT MMIO value; bits [2:0] give bgmode.
REQ-010 Port bg_enable, input, NUM_BG, per-slot enable mask.
REQ-011 Port stall, input, 1, freezes all counters and the tag pipeline while high.
REQ-012 Port col, output, 9, current column; bgno, output, BGNO_W, current slot; row, output, 8, current scanline.
REQ-013 Port frame, output, 1, frame parity; start_row and new_frame, output, 1 each, single-cycle strobes.
REQ-014 Port hblank and vblank, output, 1 each; bgused, output, 1, current slot active.
REQ-015 Ports tag_col (9), tag_bgno (BGNO_W), tag_valid (1), hcount (8), all outputs, giving the current slot delayed by PIPE_DEPTH cycles; hcount = tag_col[7:0].

Function
REQ-016 Per non-stalled cycle, bgno SHALL increment and wrap NUM_BG-1 -> 0; col SHALL increment only on that wrap.
REQ-017 start_row SHALL be high when col==H_TOTAL-1, bgno==NUM_BG-1 and stall==0; on the next edge col and bgno become 0 and row increments.
REQ-018 new_frame SHALL be high when start_row is high and row==V_TOTAL-1; on the next edge row becomes 0 and frame toggles.
REQ-019 stall==1 SHALL hold col, bgno, row, frame and every tag stage, and SHALL force start_row and new_frame low.
REQ-020 hblank SHALL equal col>=H_VISIBLE; vblank SHALL equal row>=V_VISIBLE; both combinational from current counters.
REQ-021 bgused for bgno 0..3 SHALL be bg_enable[bgno] AND the mode table: mode 0 {0,1,2,3}; mode 1 {0,1,2}; mode 2 {2,3}; modes 3-5 {2}; modes 6-7 none.
REQ-022 bgused for bgno>=4 SHALL equal bg_enable[bgno].
REQ-023 dispcnt and bg_enable SHALL be sampled per slot; a change takes effect on the next slot with no line-boundary latching.
REQ-024 Tag stage 0 SHALL capture {col, bgno, bgused & ~hblank & ~vblank} on every non-stalled edge; each later stage copies the previous stage; the outputs come from the last stage.
REQ-025 Latency col/bgno -> tag_col/tag_bgno SHALL be exactly PIPE_DEPTH non-stalled cycles.
REQ-026 tag_valid SHALL be 0 whenever the originating slot was unused or in blanking.

Reset
REQ-027 While rst==1, on each edge col, bgno, row, frame and all tag stages SHALL clear to 0; rst has priority over stall.
REQ-028 After reset the outputs SHALL read col=0, bgno=0, row=0, frame=0, tag_valid=0, tag_col=0, tag_bgno=0; strobes follow REQ-017/018 from the cleared state.
REQ-029 A reset mid-line or mid-frame SHALL restart at column 0 of row 0 with no partial strobe emitted.

Structure
REQ-030 A shared package bg_pkg SHALL hold BGNO_W (=$clog2 of NUM_BG, min 1), the bgmode enum and the mode-to-slot-mask table function.
REQ-031 The tag delay line SHALL be one sub-module, bg_tag_pipe, parametrised by width and PIPE_DEPTH with hold (stall) and sync clear.
REQ-032 The block SHALL contain no VRAM address arithmetic; it only sequences and tags.

Verification
REQ-033 Defaults, rst for 1 cycle, then 1232 cycles (308x4) -> exactly one start_row, at cycle 1231; row=1 afterwards.
REQ-034 Defaults, 308x4x228 cycles -> one new_frame, frame 0->1, row=0, col=0.
REQ-035 stall high for 10 cycles at col=100, bgno=2 -> counters and tags unchanged; resume continues at bgno=3.
REQ-036 dispcnt mode 2, bg_enable=4'hF, row 5 -> tag_valid high only for bgno 2,3 with col<240, PIPE_DEPTH cycles late.
REQ-037 NUM_BG=6, PIPE_DEPTH=3, bg_enable=6'b110000, mode 7 -> tag_valid only for bgno 4,5; tag_col lags col by 3.
REQ-038 rst asserted at row 200, col 300 with stall=1 -> next cycle all outputs 0, tag_valid=0.
